// File: rtl/l2_tlb_refill_ctrl.sv
// l2_tlb_refill_ctrl -- initiator-side refill sequencer for the L2 TLB.
//
// Takes one ITLB/DTLB miss at a time (DTLB wins when both are pending). It
// issues a single-cycle lookup to l2_tlb and samples the hit on the next
// cycle. On an L2 miss it requests a page walk from the PTW, then hands the
// walk result back to l2_tlb on the update port that matches the miss source.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  abort the current sequence
//   itlb_/dtlb_miss_i/vaddr_i level miss requests from the L1 TLBs
//   asid_i                   current ASID, captured at request acceptance
//   l2_lookup_*_o, l2_hit_i  lookup strobe to l2_tlb and its hit one cycle later
//   ptw_req_*                walk request (valid/ready)
//   ptw_resp_*               walk result pulse, error flag and payload
//   l2_update_itlb/dtlb_o    one-cycle update to l2_tlb, per source
//   busy_o                   sequencer not idle
//
// Optional build macro L2_TLB_REFILL_PERF_CNT_EN adds the saturating counters
// perf_lookup_o, perf_hit_o and perf_walk_o (CNT_WIDTH bits each).

package l2_tlb_refill_pkg;
  // Sv39 virtual address width (stands in for riscv::VLEN).
  localparam int VLEN       = 39;
  // ASID field width of the update struct; ASID_WIDTH must not exceed it.
  localparam int ASID_MAX_W = 16;

  typedef struct packed {
    logic                  valid;
    logic                  is_2m;
    logic                  is_1g;
    logic [26:0]           vpn;
    logic [ASID_MAX_W-1:0] asid;
    logic [43:0]           ppn;
  } tlb_update_t;
endpackage

module l2_tlb_refill_ctrl
  import l2_tlb_refill_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  itlb_miss_i,
  input  logic [VLEN-1:0]       itlb_vaddr_i,
  input  logic                  dtlb_miss_i,
  input  logic [VLEN-1:0]       dtlb_vaddr_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  l2_lookup_valid_o,
  output logic                  l2_lookup_is_itlb_o,
  output logic [VLEN-1:0]       l2_lookup_vaddr_o,
  input  logic                  l2_hit_i,
  output logic                  ptw_req_valid_o,
  input  logic                  ptw_req_ready_i,
  output logic [VLEN-1:0]       ptw_req_vaddr_o,
  output logic                  ptw_req_is_itlb_o,
  input  logic                  ptw_resp_valid_i,
  input  logic                  ptw_resp_error_i,
  input  tlb_update_t           ptw_resp_i,
  output tlb_update_t           l2_update_itlb_o,
  output tlb_update_t           l2_update_dtlb_o,
  output logic                  busy_o
`ifdef L2_TLB_REFILL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_lookup_o,
  output logic [CNT_WIDTH-1:0]  perf_hit_o,
  output logic [CNT_WIDTH-1:0]  perf_walk_o
`endif
);

  typedef enum logic [2:0] {
    IDLE_S,
    LOOKUP_S,
    PTW_REQ_S,
    PTW_WAIT_S,
    UPDATE_S,
    DRAIN_S
  } state_e;

  state_e                state_q, state_d;
  logic [VLEN-1:0]       vaddr_q, vaddr_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic                  is_itlb_q, is_itlb_d;
  tlb_update_t           upd_q, upd_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE_S;
      vaddr_q   <= '0;
      asid_q    <= '0;
      is_itlb_q <= 1'b0;
      upd_q     <= '0;
    end else begin
      state_q   <= state_d;
      vaddr_q   <= vaddr_d;
      asid_q    <= asid_d;
      is_itlb_q <= is_itlb_d;
      upd_q     <= upd_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    vaddr_d             = vaddr_q;
    asid_d              = asid_q;
    is_itlb_d           = is_itlb_q;
    upd_d               = upd_q;
    l2_lookup_valid_o   = 1'b0;
    l2_lookup_is_itlb_o = 1'b0;
    l2_lookup_vaddr_o   = '0;
    ptw_req_valid_o     = 1'b0;
    ptw_req_vaddr_o     = '0;
    ptw_req_is_itlb_o   = 1'b0;
    l2_update_itlb_o    = '0;
    l2_update_dtlb_o    = '0;

    unique case (state_q)
      IDLE_S: begin
        // The lookup strobe goes out in the acceptance cycle itself, so the
        // address comes straight from the selected miss input.
        if (!flush_i && (dtlb_miss_i || itlb_miss_i)) begin
          is_itlb_d           = !dtlb_miss_i;
          vaddr_d             = dtlb_miss_i ? dtlb_vaddr_i : itlb_vaddr_i;
          asid_d              = asid_i;
          l2_lookup_valid_o   = 1'b1;
          l2_lookup_is_itlb_o = is_itlb_d;
          l2_lookup_vaddr_o   = vaddr_d;
          state_d             = LOOKUP_S;
        end
      end

      LOOKUP_S: begin
        // On a hit l2_tlb refills the L1 itself; nothing more to do here.
        if (flush_i || l2_hit_i) state_d = IDLE_S;
        else                     state_d = PTW_REQ_S;
      end

      PTW_REQ_S: begin
        // Valid stays up through a flush cycle so a handshake that lands
        // there is tracked; the walk it started is then drained.
        ptw_req_valid_o   = 1'b1;
        ptw_req_vaddr_o   = vaddr_q;
        ptw_req_is_itlb_o = is_itlb_q;
        if (flush_i)              state_d = ptw_req_ready_i ? DRAIN_S : IDLE_S;
        else if (ptw_req_ready_i) state_d = PTW_WAIT_S;
      end

      PTW_WAIT_S: begin
        if (flush_i) begin
          // A response coinciding with the flush closes the walk at once.
          state_d = ptw_resp_valid_i ? IDLE_S : DRAIN_S;
        end else if (ptw_resp_valid_i) begin
          if (ptw_resp_error_i) begin
            state_d = IDLE_S;
          end else begin
            upd_d                      = ptw_resp_i;
            upd_d.asid                 = '0;
            upd_d.asid[ASID_WIDTH-1:0] = asid_q;
            upd_d.valid                = 1'b1;
            state_d                    = UPDATE_S;
          end
        end
      end

      UPDATE_S: begin
        if (!flush_i) begin
          if (is_itlb_q) l2_update_itlb_o = upd_q;
          else           l2_update_dtlb_o = upd_q;
        end
        state_d = IDLE_S;
      end

      DRAIN_S: begin
        // The PTW cannot be cancelled; swallow its response before idling.
        if (ptw_resp_valid_i) state_d = IDLE_S;
      end

      default: state_d = IDLE_S;
    endcase
  end

  assign busy_o = (state_q != IDLE_S);

`ifdef L2_TLB_REFILL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] perf_lookup_q, perf_lookup_d;
  logic [CNT_WIDTH-1:0] perf_hit_q, perf_hit_d;
  logic [CNT_WIDTH-1:0] perf_walk_q, perf_walk_d;

  // Counters stick at all-ones and survive flushes.
  always_comb begin
    perf_lookup_d = perf_lookup_q;
    perf_hit_d    = perf_hit_q;
    perf_walk_d   = perf_walk_q;
    if (l2_lookup_valid_o && (perf_lookup_q != '1))
      perf_lookup_d = perf_lookup_q + 1'b1;
    if ((state_q == LOOKUP_S) && !flush_i && l2_hit_i && (perf_hit_q != '1))
      perf_hit_d = perf_hit_q + 1'b1;
    if (ptw_req_valid_o && ptw_req_ready_i && (perf_walk_q != '1))
      perf_walk_d = perf_walk_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_lookup_q <= '0;
      perf_hit_q    <= '0;
      perf_walk_q   <= '0;
    end else begin
      perf_lookup_q <= perf_lookup_d;
      perf_hit_q    <= perf_hit_d;
      perf_walk_q   <= perf_walk_d;
    end
  end

  assign perf_lookup_o = perf_lookup_q;
  assign perf_hit_o    = perf_hit_q;
  assign perf_walk_o   = perf_walk_q;
`else
  // CNT_WIDTH only sizes the counters; keep it referenced when they are absent.
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: doc/l2_tlb_refill_ctrl.md
Name: l2_tlb_refill_ctrl

Overview:
Initiator-side sequencer for the L2 TLB. It accepts ITLB/DTLB miss requests, issues a single-cycle lookup to the L2 TLB and samples its hit result one cycle later. On an L2 miss it forwards the request to the PTW, captures the walk result, and drives it back as the L2 TLB update (itlb/dtlb update ports). It sits between the L1 TLBs, l2_tlb and the PTW, and allows one outstanding translation at a time.

Parameters:
ASID_WIDTH, 1, width of asid_i and of update ASID
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  sfence/flush; abort current sequence
itlb_miss_i  in  1  ITLB miss pending (level, held until serviced)
itlb_vaddr_i  in  riscv::VLEN  ITLB miss address
dtlb_miss_i  in  1  DTLB miss pending (level)
dtlb_vaddr_i  in  riscv::VLEN  DTLB miss address
asid_i  in  ASID_WIDTH  current ASID
l2_lookup_valid_o  out  1  one-cycle L2 read strobe
l2_lookup_is_itlb_o  out  1  lookup source: 1=ITLB, 0=DTLB
l2_lookup_vaddr_o  out  riscv::VLEN  lookup address
l2_hit_i  in  1  L2 hit, valid in the cycle after l2_lookup_valid_o
ptw_req_valid_o  out  1  walk request
ptw_req_ready_i  in  1  PTW accepts the request
ptw_req_vaddr_o  out  riscv::VLEN  walk address
ptw_req_is_itlb_o  out  1  walk source
ptw_resp_valid_i  in  1  walk done (one-cycle pulse)
ptw_resp_error_i  in  1  walk faulted (qualified by ptw_resp_valid_i)
ptw_resp_i  in  tlb_update_t  walk result
l2_update_itlb_o  out  tlb_update_t  update to l2_tlb (ITLB-sourced)
l2_update_dtlb_o  out  tlb_update_t  update to l2_tlb (DTLB-sourced)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, both update structs '0, FSM=IDLE, captured vaddr/asid/source=0.
- States: IDLE, LOOKUP, PTW_REQ, PTW_WAIT, UPDATE, DRAIN.
- IDLE: if dtlb_miss_i, select DTLB; else if itlb_miss_i, select ITLB. DTLB has priority when both are pending. Capture vaddr, asid_i and source. In the same cycle assert l2_lookup_valid_o with the captured source and address, then go to LOOKUP.
- LOOKUP (exactly 1 cycle): sample l2_hit_i.
  - Hit: go to IDLE. l2_tlb delivers the L1 refill itself, so this block issues no update.
  - Miss: go to PTW_REQ.
- PTW_REQ: hold ptw_req_valid_o=1 and vaddr/source stable until ptw_req_ready_i. On ready, go to PTW_WAIT. Valid is never dropped before ready unless flush_i.
- PTW_WAIT: on ptw_resp_valid_i:
  - Error: go to IDLE with no update.
  - No error: register ptw_resp_i, overriding .asid with the captured asid, then go to UPDATE.
- UPDATE (exactly 1 cycle): drive the registered struct with .valid=1 on l2_update_itlb_o or l2_update_dtlb_o according to the captured source. The other port stays '0. Then go to IDLE.
- Latency:
  - L2 hit: 2 cycles from request acceptance to IDLE.
  - L2 miss: lookup 2 cycles + PTW handshake + PTW latency + 1 update cycle.
- flush_i (highest priority, any state):
  - IDLE/LOOKUP/PTW_REQ/UPDATE: go to IDLE next cycle, outputs cleared, no update issued. A handshake completing in the flush cycle in PTW_REQ still goes to DRAIN.
  - PTW_WAIT: go to DRAIN. Wait for ptw_resp_valid_i, discard it, then go to IDLE.
  - ptw_resp_valid_i arriving in the same cycle as flush_i in PTW_WAIT is discarded and the FSM goes to IDLE.
- No new request is accepted outside IDLE. Misses stay pending on the level inputs.
- A miss input deasserting mid-sequence does not abort the sequence; it completes normally.
- busy_o = (state != IDLE), registered from the state.

Optional Feature:
- Macro: L2_TLB_REFILL_PERF_CNT_EN.
- When defined, adds the following outputs, each CNT_WIDTH wide and cleared on reset:
  - perf_lookup_o: +1 per l2_lookup_valid_o
  - perf_hit_o: +1 per LOOKUP-state hit
  - perf_walk_o: +1 per PTW handshake
- Counters saturate at all-ones and are not cleared by flush_i.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset mid-PTW_WAIT: assert rst_ni=0 -> all outputs 0, busy_o=0; a later ptw_resp_valid_i produces no update.
- DTLB miss vaddr=0x0000_1234_5000, l2_hit_i=1 next cycle -> one l2_lookup_valid_o pulse with is_itlb=0; no ptw_req_valid_o; busy_o back to 0 after 2 cycles.
- Simultaneous itlb_miss_i and dtlb_miss_i, both L2 misses -> DTLB serviced first; then ITLB vaddr=0x40_0000 gets a lookup; l2_update_itlb_o.valid pulses once, with asid equal to the captured asid_i=1.
- L2 miss with ptw_req_ready_i held low for 5 cycles -> ptw_req_valid_o stays 1 with vaddr stable for 5 cycles; handshake on cycle 6.
- PTW response with ptw_resp_error_i=1 -> no update on either port; IDLE next cycle.
- flush_i in PTW_WAIT, response 3 cycles later -> FSM in DRAIN, response discarded, both update ports stay '0, IDLE after the response.
